// File: rtl/stage_sequencer_if.sv
// Sequencer <-> velocity-block bundle: launch/ignition-end handshake and per-stage parameters.
// master = sequencer side, slave = velocity block / stimulus side.
interface stage_sequencer_if #(
   parameter int N = 64
);
   logic         launch;
   logic         ignition_end;
   logic [2:0]   stage_idx;
   logic [N-1:0] specific_impulse;
   logic [N-1:0] initial_weight;
   logic [N-1:0] propellant_weight;
   logic [N-1:0] burntime;
   logic         stage_rstb;
   logic         burning;
   logic         sep_pulse;
   logic         done;
   logic         timeout_err;

   modport master (
      input  launch, ignition_end,
      output stage_idx, specific_impulse, initial_weight, propellant_weight, burntime,
             stage_rstb, burning, sep_pulse, done, timeout_err
   );

   modport slave (
      output launch, ignition_end,
      input  stage_idx, specific_impulse, initial_weight, propellant_weight, burntime,
             stage_rstb, burning, sep_pulse, done, timeout_err
   );
endinterface

// File: rtl/stage_sequencer.sv
// Per-burn propulsion parameter sequencer feeding the rocket-equation velocity block.
// Optional burn watchdog enabled by defining STAGE_WATCHDOG_EN.
//
// state | meaning
// IDLE  | waiting for launch
// LOAD  | parameters for stage_idx presented, velocity block held in reset
// BURN  | velocity block running, waiting for ignition_end (or watchdog)
// SEP   | stage separation hold after burns 1 and 2
// COAST | coast between burns 3 and 4
// DONE  | mission complete, sticky until reset
module stage_sequencer #(
   parameter int          N             = 64,
   parameter int unsigned TICKS_PER_SEC = 50,
   parameter int unsigned SEP_HOLD      = 4,
   parameter int unsigned COAST_CYC     = 8,
   parameter int unsigned ISP_1         = 263,
   parameter int unsigned ISP_2         = 421,
   parameter int unsigned ISP_3         = 421,
   parameter int unsigned PROP_1        = 2077000,
   parameter int unsigned PROP_2        = 456100,
   parameter int unsigned PROP_3        = 39136,
   parameter int unsigned PROP_4        = 83864,
   parameter int unsigned BURN_1        = 168,
   parameter int unsigned BURN_2        = 360,
   parameter int unsigned BURN_3        = 165,
   parameter int unsigned BURN_4        = 335,
   parameter int unsigned DRY_1         = 137000,
   parameter int unsigned DRY_2         = 40100,
   parameter int unsigned DRY_3         = 15200,
   parameter int unsigned PAYLOAD       = 27003,
   parameter int unsigned WD_MARGIN     = 10
) (
   input logic               CLK,
   input logic               RESETB,
   stage_sequencer_if.master bus
);

   // Stage 3 stays attached through burn 4, so burn 4 still carries DRY_3.
   localparam logic [N-1:0] MASS_4 = N'(PROP_4) + N'(DRY_3) + N'(PAYLOAD);
   localparam logic [N-1:0] MASS_3 = MASS_4 + N'(PROP_3);
   localparam logic [N-1:0] MASS_2 = MASS_3 + N'(PROP_2) + N'(DRY_2);
   localparam logic [N-1:0] MASS_1 = MASS_2 + N'(PROP_1) + N'(DRY_1);

   typedef enum logic [2:0] {IDLE, LOAD, BURN, SEP, COAST, DONE} state_t;

   state_t       r_state, w_state_nxt;
   logic [2:0]   r_idx, w_idx_nxt;
   logic [N-1:0] r_isp, r_mass, r_prop, r_burn;
   logic [N-1:0] w_isp, w_mass, w_prop, w_burn;
   logic [31:0]  r_tick, r_sec;
   logic [15:0]  r_hold;
   logic         r_timeout;
   logic         w_ign_valid, w_wd_hit, w_burn_end;
   logic         w_stage_rstb, w_burning, w_sep_pulse, w_done;

   // First BURN cycle is the only one with both counters at zero; a stale flag is dropped there.
   assign w_ign_valid = bus.ignition_end && !(r_tick == 32'd0 && r_sec == 32'd0);

`ifdef STAGE_WATCHDOG_EN
   // Fires on the tick that would carry the seconds counter to BURN_k + WD_MARGIN.
   assign w_wd_hit = (r_state == BURN) && (r_tick == 32'(TICKS_PER_SEC - 1)) &&
                     ((N'(r_sec) + N'(1)) == (r_burn + N'(WD_MARGIN)));
`else
   assign w_wd_hit = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_stage_rstb = 1'b0;
      w_burning    = 1'b0;
      w_sep_pulse  = 1'b0;
      w_done       = 1'b0;
      w_burn_end   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.launch) begin
               w_state_nxt = LOAD;
               w_idx_nxt   = 3'd1;
            end
         end
         LOAD: w_state_nxt = BURN;
         BURN: begin
            w_stage_rstb = 1'b1;
            w_burning    = 1'b1;
            w_burn_end   = w_ign_valid || w_wd_hit;
            if (w_burn_end) begin
               case (r_idx)
                  3'd1, 3'd2: w_state_nxt = SEP;
                  3'd3:       w_state_nxt = COAST;
                  default:    w_state_nxt = DONE;
               endcase
            end
         end
         SEP: begin
            w_sep_pulse = (r_hold == 16'(SEP_HOLD - 1));
            if (r_hold == 16'd0) begin
               w_state_nxt = LOAD;
               w_idx_nxt   = r_idx + 3'd1;
            end
         end
         COAST: begin
            if (r_hold == 16'd0) begin
               w_state_nxt = LOAD;
               w_idx_nxt   = 3'd4;
            end
         end
         DONE:    w_done = 1'b1;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_isp  = N'(ISP_3);
      w_mass = MASS_4;
      w_prop = N'(PROP_4);
      w_burn = N'(BURN_4);
      case (w_idx_nxt)
         3'd1: begin w_isp = N'(ISP_1); w_mass = MASS_1; w_prop = N'(PROP_1); w_burn = N'(BURN_1); end
         3'd2: begin w_isp = N'(ISP_2); w_mass = MASS_2; w_prop = N'(PROP_2); w_burn = N'(BURN_2); end
         3'd3: begin w_isp = N'(ISP_3); w_mass = MASS_3; w_prop = N'(PROP_3); w_burn = N'(BURN_3); end
         default: ;
      endcase
   end

   // Parameters latch on entry to LOAD so they are valid while the velocity block is still in reset.
   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         r_idx     <= 3'd0;
         r_isp     <= '0;
         r_mass    <= '0;
         r_prop    <= '0;
         r_burn    <= N'(1);
         r_tick    <= 32'd0;
         r_sec     <= 32'd0;
         r_hold    <= 16'd0;
         r_timeout <= 1'b0;
      end else begin
         r_idx <= w_idx_nxt;
         if (w_state_nxt == LOAD && r_state != LOAD) begin
            r_isp  <= w_isp;
            r_mass <= w_mass;
            r_prop <= w_prop;
            r_burn <= w_burn;
         end
         if (r_state == LOAD) begin
            r_tick <= 32'd0;
            r_sec  <= 32'd0;
         end else if (r_state == BURN) begin
            if (r_tick == 32'(TICKS_PER_SEC - 1)) begin
               r_tick <= 32'd0;
               r_sec  <= r_sec + 32'd1;
            end else begin
               r_tick <= r_tick + 32'd1;
            end
         end
         if (r_state == BURN && w_state_nxt == SEP)        r_hold <= 16'(SEP_HOLD - 1);
         else if (r_state == BURN && w_state_nxt == COAST) r_hold <= 16'(COAST_CYC - 1);
         else if (r_hold != 16'd0)                         r_hold <= r_hold - 16'd1;
         if (w_wd_hit) r_timeout <= 1'b1;
      end
   end

   assign bus.stage_idx         = r_idx;
   assign bus.specific_impulse  = r_isp;
   assign bus.initial_weight    = r_mass;
   assign bus.propellant_weight = r_prop;
   assign bus.burntime          = r_burn;
   assign bus.stage_rstb        = w_stage_rstb;
   assign bus.burning           = w_burning;
   assign bus.sep_pulse         = w_sep_pulse;
   assign bus.done              = w_done;
   assign bus.timeout_err       = r_timeout;

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized mission bench for stage_sequencer against a staging-rule reference model.
// Watchdog expectations follow STAGE_WATCHDOG_EN.
module tb_stage_sequencer;

   localparam int TPS       = 2;
   localparam int SEP_HOLD  = 4;
   localparam int COAST_CYC = 8;
   localparam int WD_MARGIN = 10;
   localparam int PAYLOAD   = 27003;
   localparam int unsigned ISP_T  [4] = '{263, 421, 421, 421};
   localparam int unsigned PROP_T [4] = '{2077000, 456100, 39136, 83864};
   localparam int unsigned BURN_T [4] = '{168, 360, 165, 335};
   localparam int unsigned DRY_T  [3] = '{137000, 40100, 15200};

   logic CLK;
   logic RESETB;
   int   n_tests = 0;
   int   n_fail  = 0;

   stage_sequencer_if #(.N(64)) sif ();

   stage_sequencer #(.N(64), .TICKS_PER_SEC(TPS), .SEP_HOLD(SEP_HOLD),
                     .COAST_CYC(COAST_CYC), .WD_MARGIN(WD_MARGIN)) dut (
      .CLK    (CLK),
      .RESETB (RESETB),
      .bus    (sif.master)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Burn k (1..4): remaining propellant, dry mass of every stage still attached, plus payload.
   function automatic longint unsigned model_mass(input int k);
      longint unsigned m = PAYLOAD;
      int attached_from = (k > 3) ? 3 : k;
      for (int j = k; j <= 4; j++) m += PROP_T[j-1];
      for (int j = attached_from; j <= 3; j++) m += DRY_T[j-1];
      return m;
   endfunction

   task automatic check_params(input string tag, input int k);
      check({tag, "_isp"},  sif.specific_impulse,  64'(ISP_T[k-1]));
      check({tag, "_mass"}, sif.initial_weight,    64'(model_mass(k)));
      check({tag, "_prop"}, sif.propellant_weight, 64'(PROP_T[k-1]));
      check({tag, "_burn"}, sif.burntime,          64'(BURN_T[k-1]));
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_idx"},   sif.stage_idx, 0);
      check({tag, "_isp"},   sif.specific_impulse, 0);
      check({tag, "_mass"},  sif.initial_weight, 0);
      check({tag, "_prop"},  sif.propellant_weight, 0);
      check({tag, "_burn"},  sif.burntime, 1);
      check({tag, "_rstb"},  sif.stage_rstb, 0);
      check({tag, "_brn"},   sif.burning, 0);
      check({tag, "_sep"},   sif.sep_pulse, 0);
      check({tag, "_done"},  sif.done, 0);
      check({tag, "_tmo"},   sif.timeout_err, 0);
   endtask

   // Leaves the bench at the mid-cycle point of the LOAD cycle for stage 1.
   task automatic start_mission();
      sif.launch = 1'b1;
      @(negedge CLK);
      sif.launch = 1'b0;
   endtask

   // Entered at the LOAD cycle of burn k; returns at the next LOAD (k<4), after DONE checks,
   // or right after an asynchronous reset when abort_after > 0.
   task automatic do_burn(input int k, input int abort_after);
      bit stale = 1'($urandom_range(0, 1));
      int len   = $urandom_range(1, 30);
      int cyc   = 0;
      int pulses = 0;
      int rstb_hi = 0;
      int hold  = (k < 3) ? SEP_HOLD : COAST_CYC;
      check("load_idx", sif.stage_idx, 64'(k));
      check("load_rstb", sif.stage_rstb, 0);
      check_params("load", k);
      sif.ignition_end = stale;
      @(negedge CLK);
      check("burn_rstb", sif.stage_rstb, 1);
      check("burn_flag", sif.burning, 1);
      @(negedge CLK);
      check("stale_ign_ignored", sif.burning, 1);
      sif.ignition_end = 1'b0;
      if (abort_after > 0) begin
         repeat (abort_after) @(negedge CLK);
         RESETB = 1'b0;
         #1;
         check_reset("abort");
         @(negedge CLK);
         RESETB = 1'b1;
         return;
      end
      repeat (len) begin
         sif.launch = 1'($urandom_range(0, 1));
         @(negedge CLK);
      end
      sif.launch = 1'b0;
      check("burn_hold", sif.burning, 1);
      check("burn_idx", sif.stage_idx, 64'(k));
      check_params("burn", k);
      sif.ignition_end = 1'b1;
      @(negedge CLK);
      sif.ignition_end = 1'b0;
      check("end_rstb", sif.stage_rstb, 0);
      check("end_brn", sif.burning, 0);
      if (k == 4) begin
         check("done_set", sif.done, 1);
         check("done_sep", sif.sep_pulse, 0);
         repeat (10) begin
            sif.ignition_end = 1'($urandom_range(0, 1));
            sif.launch       = 1'($urandom_range(0, 1));
            @(negedge CLK);
         end
         sif.ignition_end = 1'b0;
         sif.launch       = 1'b0;
         check("done_sticky", sif.done, 1);
         check("done_idx", sif.stage_idx, 4);
         check("done_rstb", sif.stage_rstb, 0);
         check_params("done", 4);
         return;
      end
      check("gap_first_sep", sif.sep_pulse, (k < 3) ? 1 : 0);
      while (sif.stage_idx == 3'(k) && cyc < 100) begin
         pulses  += int'(sif.sep_pulse);
         rstb_hi += int'(sif.stage_rstb);
         sif.ignition_end = 1'($urandom_range(0, 1));
         sif.launch       = 1'($urandom_range(0, 1));
         @(negedge CLK);
         cyc++;
      end
      sif.ignition_end = 1'b0;
      sif.launch       = 1'b0;
      check("gap_len", cyc, hold);
      check("gap_pulses", pulses, (k < 3) ? 1 : 0);
      check("gap_rstb", rstb_hi, 0);
   endtask

   task automatic full_mission();
      start_mission();
      for (int k = 1; k <= 4; k++) do_burn(k, 0);
   endtask

   initial begin
      int n;
      int exp_n;
      RESETB = 1'b0;
      sif.launch = 1'b0;
      sif.ignition_end = 1'b0;
      repeat (3) @(negedge CLK);
      check_reset("por");
      RESETB = 1'b1;
      repeat ($urandom_range(1, 5)) begin
         sif.ignition_end = 1'($urandom_range(0, 1));
         @(negedge CLK);
      end
      sif.ignition_end = 1'b0;
      check("idle_idx", sif.stage_idx, 0);

      full_mission();

      RESETB = 1'b0;
      @(negedge CLK);
      RESETB = 1'b1;
      @(negedge CLK);
      start_mission();
      do_burn(1, 0);
      do_burn(2, $urandom_range(1, 20));
      @(negedge CLK);
      check("post_abort_idle", sif.stage_idx, 0);

      full_mission();

      // Long burn with no ignition_end: watchdog trips or BURN keeps waiting.
      RESETB = 1'b0;
      @(negedge CLK);
      RESETB = 1'b1;
      @(negedge CLK);
      start_mission();
      @(negedge CLK);
      n = 0;
      while (sif.burning && n < 400) begin
         n++;
         @(negedge CLK);
      end
`ifdef STAGE_WATCHDOG_EN
      exp_n = (BURN_T[0] + WD_MARGIN) * TPS;
      check("wd_cycles", n, exp_n);
      check("wd_err", sif.timeout_err, 1);
      check("wd_sep", sif.sep_pulse, 1);
      check("wd_idx", sif.stage_idx, 1);
`else
      exp_n = 400;
      check("nowd_cycles", n, exp_n);
      check("nowd_burning", sif.burning, 1);
      check("nowd_err", sif.timeout_err, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation did not complete, tests=%0d", n_tests);
      $fatal(1);
   end

endmodule
